// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and state types for the framebuffer arbiter
package fb_pkg;
    localparam int H_RES       = 1024;
    localparam int V_RES       = 768;
    localparam int FRAME_WORDS = H_RES * V_RES;

    typedef enum logic {SHOW, PENDING} swap_state_t;
    typedef enum logic [1:0] {NONE, DISP, FILT} owner_t;
endpackage

// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: tear-free front/back bank swap, taken only at end of screen
module fb_swap_ctrl
    import fb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic frame_done,
    input  logic screenend,
    output logic disp_bank,
    output logic swap_pending,
    output logic swap_overflow
);
    swap_state_t state, state_nxt;
    logic bank_nxt, ovf_nxt;

    // a finished frame queues one swap; screenend consumes it (or a same-cycle frame)
    always_comb begin
        state_nxt    = (state == SHOW) ? ((frame_done & ~screenend) ? PENDING : SHOW)
                                       : ((screenend & ~frame_done) ? SHOW : PENDING);
        bank_nxt     = disp_bank ^ (screenend & (frame_done | (state == PENDING)));
        ovf_nxt      = swap_overflow | ((state == PENDING) & frame_done & ~screenend);
        swap_pending = (state == PENDING);
    end

    // bank, state and sticky overflow registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SHOW;
            disp_bank     <= 1'b0;
            swap_overflow <= 1'b0;
        end else begin
            state         <= state_nxt;
            disp_bank     <= bank_nxt;
            swap_overflow <= ovf_nxt;
        end
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one double-buffered RAM between display fetch and filter
module vga_fb_arbiter
    import fb_pkg::*;
#(
    parameter int H_RES  = fb_pkg::H_RES,
    parameter int V_RES  = fb_pkg::V_RES,
    parameter int DATA_W = 12,
    parameter int OFS_W  = 20,
    parameter int ADDR_W = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_stb,
    input  logic              active,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              screenend,
    input  logic              filt_req,
    input  logic              filt_we,
    input  logic [OFS_W-1:0]  filt_addr,
    input  logic [DATA_W-1:0] filt_wdata,
    output logic              filt_gnt,
    output logic              filt_rvalid,
    output logic [DATA_W-1:0] filt_rdata,
    input  logic              filt_frame_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_rgb,
    output logic              pix_valid,
    output logic              disp_bank,
    output logic              swap_pending,
    output logic              swap_overflow
);
    localparam int H_SHIFT = $clog2(H_RES);

    logic             disp_slot, blank_slot;
    logic [OFS_W-1:0] disp_ofs;
    owner_t           owner, owner_nxt;

    fb_swap_ctrl u_swap (
        .clk          (clk),
        .reset        (reset),
        .frame_done   (filt_frame_done),
        .screenend    (screenend),
        .disp_bank    (disp_bank),
        .swap_pending (swap_pending),
        .swap_overflow(swap_overflow)
    );

    // display owns any strobed active pixel; filter takes every other requested cycle
    always_comb begin
        disp_slot  = pix_stb & active;
        blank_slot = pix_stb & ~active;
        filt_gnt   = filt_req & ~disp_slot;
        disp_ofs   = (OFS_W'(y) << H_SHIFT) | OFS_W'(x);
        mem_en     = disp_slot | filt_gnt;
        mem_we     = filt_gnt & filt_we;
        mem_addr   = disp_slot ? ADDR_W'({disp_bank, disp_ofs}) : ADDR_W'({~disp_bank, filt_addr});
        mem_wdata  = filt_wdata;
        owner_nxt  = disp_slot ? DISP : (filt_gnt & ~filt_we) ? FILT : NONE;
    end

    // route the RAM's one-cycle-late read data to whoever issued the read
    always_ff @(posedge clk) begin
        if (reset) begin
            owner       <= NONE;
            pix_rgb     <= '0;
            pix_valid   <= 1'b0;
            filt_rvalid <= 1'b0;
            filt_rdata  <= '0;
        end else begin
            owner       <= owner_nxt;
            pix_valid   <= (owner == DISP) | blank_slot;
            pix_rgb     <= (owner == DISP) ? mem_rdata : blank_slot ? '0 : pix_rgb;
            filt_rvalid <= (owner == FILT);
            filt_rdata  <= (owner == FILT) ? mem_rdata : filt_rdata;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed plan checks followed by randomized checks against a behavioural model
module tb_vga_fb_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        pix_stb = 1'b0, active = 1'b0, screenend = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic        filt_req = 1'b0, filt_we = 1'b0, filt_frame_done = 1'b0;
    logic [19:0] filt_addr = '0;
    logic [11:0] filt_wdata = '0;
    logic        filt_gnt, filt_rvalid, mem_en, mem_we;
    logic [11:0] filt_rdata, mem_wdata, pix_rgb;
    logic [11:0] mem_rdata = '0;
    logic [20:0] mem_addr;
    logic        pix_valid, disp_bank, swap_pending, swap_overflow;

    logic        rd_ovr = 1'b1, mem_clr = 1'b0;
    logic [11:0] rd_val = '0;
    logic [11:0] env_mem [int];
    logic [11:0] mmem [int];
    int tests = 0, fails = 0;

    vga_fb_arbiter dut (
        .clk(clk), .reset(reset), .pix_stb(pix_stb), .active(active), .x(x), .y(y),
        .screenend(screenend), .filt_req(filt_req), .filt_we(filt_we), .filt_addr(filt_addr),
        .filt_wdata(filt_wdata), .filt_gnt(filt_gnt), .filt_rvalid(filt_rvalid),
        .filt_rdata(filt_rdata), .filt_frame_done(filt_frame_done), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_rgb(pix_rgb), .pix_valid(pix_valid), .disp_bank(disp_bank),
        .swap_pending(swap_pending), .swap_overflow(swap_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] patt(int a);
        return 12'((a * 7 + 3) ^ (a >> 12));
    endfunction

    function automatic logic [11:0] mread(int a);
        return mmem.exists(a) ? mmem[a] : patt(a);
    endfunction

    // single-port RAM environment with one-cycle read latency
    always @(posedge clk) begin
        if (mem_clr) env_mem.delete();
        else if (mem_en && mem_we) env_mem[int'(mem_addr)] = mem_wdata;
        if (mem_en && !mem_we)
            mem_rdata <= rd_ovr ? rd_val
                       : (env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : patt(int'(mem_addr)));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int a, pk, q, mb, mp, mo;
    logic [11:0] pdat, e_rgb, e_fd;
    logic e_pv, e_fv, prev, disp, gnt, blank;

    initial begin
        tick; tick;
        chk("rst_pix_rgb", pix_rgb, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_filt_rvalid", filt_rvalid, 0);
        chk("rst_filt_rdata", filt_rdata, 0);
        chk("rst_disp_bank", disp_bank, 0);
        chk("rst_swap_pending", swap_pending, 0);
        chk("rst_swap_overflow", swap_overflow, 0);
        reset = 1'b0;
        #1 chk("idle_mem_en", mem_en, 0);

        pix_stb = 1; active = 1; x = 5; y = 2; rd_val = 12'hABC;
        #1 chk("disp_en", mem_en, 1);
        chk("disp_we", mem_we, 0);
        chk("disp_addr", mem_addr, 32'h805);
        tick; pix_stb = 0; active = 0;
        #1 chk("disp_valid_early", pix_valid, 0);
        tick;
        chk("disp_rgb", pix_rgb, 12'hABC);
        chk("disp_valid", pix_valid, 1);
        tick;
        chk("disp_valid_pulse", pix_valid, 0);

        pix_stb = 1; active = 0;
        #1 chk("blank_en", mem_en, 0);
        tick; pix_stb = 0;
        chk("blank_rgb", pix_rgb, 0);
        chk("blank_valid", pix_valid, 1);
        tick;

        pix_stb = 1; active = 1; filt_req = 1; filt_we = 1; filt_addr = 20'h12345; filt_wdata = 12'h5A5;
        #1 chk("conflict_gnt", filt_gnt, 0);
        tick; pix_stb = 0; active = 0;
        #1 chk("retry_gnt", filt_gnt, 1);
        chk("retry_addr", mem_addr, 32'h112345);
        chk("retry_we", mem_we, 1);
        chk("retry_wdata", mem_wdata, 12'h5A5);
        tick;

        filt_we = 0; filt_addr = 20'h10; rd_val = 12'h3C0;
        #1 chk("frd_gnt", filt_gnt, 1);
        chk("frd_addr", mem_addr, 32'h100010);
        chk("frd_we", mem_we, 0);
        tick; filt_req = 0;
        #1 chk("frd_valid_early", filt_rvalid, 0);
        tick;
        chk("frd_valid", filt_rvalid, 1);
        chk("frd_data", filt_rdata, 12'h3C0);
        chk("frd_no_pix", pix_valid, 0);
        tick;
        chk("frd_valid_pulse", filt_rvalid, 0);
        chk("frd_data_hold", filt_rdata, 12'h3C0);

        filt_frame_done = 1; screenend = 1; tick; filt_frame_done = 0; screenend = 0;
        chk("show_both_bank", disp_bank, 1);
        chk("show_both_pend", swap_pending, 0);
        filt_frame_done = 1; tick; filt_frame_done = 0;
        chk("pend_set", swap_pending, 1);
        filt_frame_done = 1; screenend = 1; pix_stb = 1; active = 1; x = 3; y = 0;
        #1 chk("swap_cycle_addr", mem_addr, 32'h100003);
        tick; filt_frame_done = 0; screenend = 0; pix_stb = 0; active = 0;
        chk("pend_both_bank", disp_bank, 0);
        chk("pend_both_pend", swap_pending, 1);
        chk("pend_both_ovf", swap_overflow, 0);
        screenend = 1; tick; screenend = 0;
        chk("pend_se_bank", disp_bank, 1);
        chk("pend_se_pend", swap_pending, 0);
        filt_frame_done = 1; tick;
        chk("fd1_pend", swap_pending, 1);
        chk("fd1_ovf", swap_overflow, 0);
        tick; filt_frame_done = 0;
        chk("fd2_ovf", swap_overflow, 1);
        chk("fd2_pend", swap_pending, 1);
        screenend = 1; tick; screenend = 0;
        chk("se_bank0", disp_bank, 0);
        chk("se_pend", swap_pending, 0);
        chk("ovf_sticky", swap_overflow, 1);
        filt_frame_done = 1; tick; filt_frame_done = 0; screenend = 1; tick; screenend = 0;
        chk("se_bank1", disp_bank, 1);
        pix_stb = 1; active = 1; x = 1; y = 1;
        #1 chk("bank1_disp_addr", mem_addr, 32'h100401);
        tick; pix_stb = 0; active = 0; filt_req = 1; filt_we = 1; filt_addr = 20'h20;
        #1 chk("bank1_filt_addr", mem_addr, 32'h000020);
        tick; filt_req = 0;

        filt_frame_done = 1; tick; filt_frame_done = 0;
        chk("rst_mid_pend", swap_pending, 1);
        filt_req = 1; filt_we = 0; filt_addr = 20'h55;
        #1 chk("rst_mid_gnt", filt_gnt, 1);
        tick; filt_req = 0; reset = 1;
        tick; reset = 0;
        chk("rst_mid_rvalid", filt_rvalid, 0);
        chk("rst_mid_pix_valid", pix_valid, 0);
        chk("rst_mid_bank", disp_bank, 0);
        chk("rst_mid_pend2", swap_pending, 0);
        chk("rst_mid_ovf", swap_overflow, 0);
        tick;
        chk("rst_mid_discard", filt_rvalid, 0);

        reset = 1; mem_clr = 1; rd_ovr = 0;
        tick; tick;
        reset = 0; mem_clr = 0;
        mb = 0; mp = 0; mo = 0; pk = 0; pdat = '0;
        e_pv = 0; e_fv = 0; e_rgb = '0; e_fd = '0; prev = 0;
        mmem.delete();
        for (int i = 0; i < 3000; i++) begin
            pix_stb = prev ? 1'b0 : 1'($urandom_range(0, 1));
            prev = pix_stb;
            active = ($urandom_range(0, 3) != 0);
            x = 10'($urandom_range(0, 127));
            y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 767)) : 10'd0;
            filt_req = 1'($urandom_range(0, 1));
            filt_we = 1'($urandom_range(0, 1));
            filt_addr = 20'($urandom_range(0, 127));
            filt_wdata = 12'($urandom);
            filt_frame_done = ($urandom_range(0, 15) == 0);
            screenend = ($urandom_range(0, 23) == 0);
            #1;
            disp = pix_stb & active;
            blank = pix_stb & ~active;
            gnt = filt_req & ~disp;
            chk("rnd_gnt", filt_gnt, gnt);
            chk("rnd_en", mem_en, disp | gnt);
            a = 0;
            if (disp) begin
                a = mb * (1 << 20) + int'(y) * 1024 + int'(x);
                chk("rnd_disp_we", mem_we, 0);
                chk("rnd_disp_addr", mem_addr, a);
            end else if (gnt) begin
                a = (1 - mb) * (1 << 20) + int'(filt_addr);
                chk("rnd_filt_we", mem_we, filt_we);
                chk("rnd_filt_addr", mem_addr, a);
                if (filt_we) chk("rnd_wdata", mem_wdata, filt_wdata);
            end else chk("rnd_idle_we", mem_we, 0);
            chk("rnd_pix_valid", pix_valid, e_pv);
            chk("rnd_pix_rgb", pix_rgb, e_rgb);
            chk("rnd_filt_rvalid", filt_rvalid, e_fv);
            chk("rnd_filt_rdata", filt_rdata, e_fd);
            chk("rnd_bank", disp_bank, mb);
            chk("rnd_pending", swap_pending, mp);
            chk("rnd_overflow", swap_overflow, mo);
            e_pv = (pk == 1) | blank;
            e_rgb = (pk == 1) ? pdat : blank ? 12'd0 : e_rgb;
            e_fv = (pk == 2);
            e_fd = (pk == 2) ? pdat : e_fd;
            if (disp) begin pk = 1; pdat = mread(a); end
            else if (gnt && !filt_we) begin pk = 2; pdat = mread(a); end
            else pk = 0;
            if (gnt && filt_we) mmem[a] = filt_wdata;
            q = mp + int'(filt_frame_done);
            if (screenend && q > 0) begin mb = 1 - mb; q--; end
            if (q > 1) begin mo = 1; q = 1; end
            mp = q;
            tick;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
